// File: rtl/ttl_ctr_pkg.sv
// Shared definitions for the 74AS867-style up/down counter command driver:
// op codes, FSM states, counter mode-select encodings and small decode helpers.
package ttl_ctr_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int STEP_W_DEF = 4;

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;

  localparam logic [1:0] MODE_CLR  = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;
  localparam logic [1:0] MODE_UP   = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_SUB;
  endfunction

  function automatic logic op_counts(input logic [2:0] op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Hold (MODE_UP with enables high) is the safe choice for anything unlisted.
  function automatic logic [1:0] op_mode(input logic [2:0] op);
    case (op)
      OP_CLR:         return MODE_CLR;
      OP_LOAD:        return MODE_LOAD;
      OP_DEC, OP_SUB: return MODE_DOWN;
      default:        return MODE_UP;
    endcase
  endfunction

endpackage

// File: rtl/updown_counter_driver.sv
// Drives an external 8-bit up/down counter one clock per step from valid/ready requests,
// keeping a shadow count, accumulating RCO wraps and checking Q readback at completion.
module updown_counter_driver
  import ttl_ctr_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  output logic             done,
  output logic             err,
  output logic             wrap,
  output logic [WIDTH-1:0] count,
  output logic             ctr_s1,
  output logic             ctr_s0,
  output logic             ctr_enp_n,
  output logic             ctr_ent_n,
  output logic [WIDTH-1:0] ctr_d,
  input  logic             ctr_rco_n,
  input  logic [WIDTH-1:0] ctr_q
);

  state_e              state_q;
  logic [2:0]          op_q;
  logic [WIDTH-1:0]    data_q;
  logic [STEP_W-1:0]   steps_q;
  logic                illegal_q;
  logic                wrap_acc_q;
  logic [WIDTH-1:0]    count_q;
  logic                done_q;
  logic                wrap_q;
  logic                ready_q;
  logic [1:0]          mode_q;
  logic                en_n_q;
  logic [WIDTH-1:0]    pin_d_q;

  logic [WIDTH-1:0]    count_d;
  logic [STEP_W-1:0]   req_steps_d;
  logic                wrap_acc_d;

  always_comb begin
    count_d = count_q;
    case (op_q)
      OP_CLR:         count_d = '0;
      OP_LOAD:        count_d = data_q;
      OP_INC, OP_ADD: count_d = count_q + WIDTH'(1);
      OP_DEC, OP_SUB: count_d = count_q - WIDTH'(1);
      default:        count_d = count_q;
    endcase
  end

  always_comb begin
    req_steps_d = STEP_W'(1);
    if ((req_op == OP_ADD) || (req_op == OP_SUB)) begin
      req_steps_d = req_data[STEP_W-1:0];
    end
  end

  // RCO is only meaningful while the counter is actually enabled to count.
  assign wrap_acc_d = wrap_acc_q | (op_counts(op_q) & ~ctr_rco_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      op_q       <= OP_CLR;
      data_q     <= '0;
      steps_q    <= '0;
      illegal_q  <= 1'b0;
      wrap_acc_q <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      ready_q    <= 1'b0;
      mode_q     <= MODE_CLR;
      en_n_q     <= 1'b1;
      pin_d_q    <= '0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          mode_q  <= MODE_UP;
          en_n_q  <= 1'b1;
          pin_d_q <= '0;
        end
        ST_IDLE: begin
          if (req_valid && ready_q) begin
            ready_q   <= 1'b0;
            op_q      <= req_op;
            data_q    <= req_data;
            steps_q   <= req_steps_d;
            illegal_q <= ~op_legal(req_op);
            if (!op_legal(req_op) || (req_steps_d == '0)) begin
              state_q <= ST_CHECK;
              done_q  <= 1'b1;
              wrap_q  <= wrap_acc_q;
            end else begin
              state_q <= ST_EXEC;
              mode_q  <= op_mode(req_op);
              en_n_q  <= ~op_counts(req_op);
              pin_d_q <= (req_op == OP_LOAD) ? req_data : '0;
            end
          end
        end
        ST_EXEC: begin
          count_q <= count_d;
          steps_q <= steps_q - STEP_W'(1);
          if (steps_q == STEP_W'(1)) begin
            state_q    <= ST_CHECK;
            done_q     <= 1'b1;
            wrap_q     <= wrap_acc_d;
            wrap_acc_q <= 1'b0;
            mode_q     <= MODE_UP;
            en_n_q     <= 1'b1;
            pin_d_q    <= '0;
          end else begin
            wrap_acc_q <= wrap_acc_d;
          end
        end
        ST_CHECK: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Readback must see Q after the final step's edge, so the compare is taken in the CHECK cycle.
  assign err       = done_q & (illegal_q | (ctr_q != count_q));
  assign done      = done_q;
  assign wrap      = wrap_q;
  assign count     = count_q;
  assign req_ready = ready_q;
  assign ctr_s1    = mode_q[1];
  assign ctr_s0    = mode_q[0];
  assign ctr_enp_n = en_n_q;
  assign ctr_ent_n = en_n_q;
  assign ctr_d     = pin_d_q;

endmodule

// File: tb/tb_updown_counter_driver.sv
// Bench for updown_counter_driver paired with a behavioural 8-bit up/down counter and an
// arithmetic reference for count, wrap, err and completion timing.
module tb_updown_counter_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic [7:0] req_data = 8'h00;
  logic       done, err, wrap;
  logic [7:0] count;
  logic       ctr_s1, ctr_s0, ctr_enp_n, ctr_ent_n;
  logic [7:0] ctr_d;
  logic       ctr_rco_n;
  logic [7:0] ctr_q;

  logic [7:0] model_q = 8'hA5;
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'h00;
  int         exp_count = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  updown_counter_driver dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .done(done), .err(err), .wrap(wrap), .count(count),
    .ctr_s1(ctr_s1), .ctr_s0(ctr_s0), .ctr_enp_n(ctr_enp_n), .ctr_ent_n(ctr_ent_n),
    .ctr_d(ctr_d), .ctr_rco_n(ctr_rco_n), .ctr_q(ctr_q)
  );

  // Behavioural 74AS867-style counter
  always @(posedge clk) begin
    case ({ctr_s1, ctr_s0})
      2'b00: model_q <= 8'h00;
      2'b10: model_q <= ctr_d;
      2'b11: if (!ctr_enp_n && !ctr_ent_n) model_q <= model_q + 8'h01;
      default: if (!ctr_enp_n && !ctr_ent_n) model_q <= model_q - 8'h01;
    endcase
  end
  assign ctr_rco_n = !(!ctr_ent_n && ((ctr_s1 && ctr_s0 && model_q == 8'hFF) ||
                                      (!ctr_s1 && ctr_s0 && model_q == 8'h00)));
  assign ctr_q = force_en ? force_val : model_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, "_idle_s"}, {ctr_s1, ctr_s0}, 2'b11);
    chk({tag, "_idle_en"}, {ctr_enp_n, ctr_ent_n}, 2'b11);
    chk({tag, "_idle_d"}, ctr_d, 8'h00);
  endtask

  // Entered and left at a negedge; issues one request and checks it through to ready returning.
  task automatic run_op(input logic [2:0] op, input logic [7:0] data);
    int     n, steps, nc, w;
    logic   legal, exp_wrap, exp_err;
    logic [1:0] exp_mode;
    legal = (op < 3'd6);
    n = (op == 3'd4 || op == 3'd5) ? int'(data[3:0]) : 1;
    steps = legal ? n : 0;
    nc = exp_count;
    exp_wrap = 1'b0;
    exp_mode = 2'b11;
    case (op)
      3'd0: begin nc = 0; exp_mode = 2'b00; end
      3'd1: begin nc = int'(data); exp_mode = 2'b10; end
      3'd2, 3'd4: begin nc = (exp_count + n) % 256; exp_wrap = (exp_count + n) > 255; end
      3'd3, 3'd5: begin nc = (exp_count - n + 256) % 256; exp_wrap = n > exp_count;
                        exp_mode = 2'b01; end
      default: nc = exp_count;
    endcase
    exp_err = !legal || (force_en && force_val != nc[7:0]);

    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_data = data;
    @(posedge clk);
    #1 req_valid = 1'b0; req_op = 3'($urandom); req_data = 8'($urandom);

    for (int k = 1; k <= steps + 1; k++) begin
      @(negedge clk);
      if (k <= steps) begin
        chk("exec_done_low", done, 1'b0);
        chk("exec_ready_low", req_ready, 1'b0);
        chk("exec_mode", {ctr_s1, ctr_s0}, exp_mode);
        chk("exec_en", {ctr_enp_n, ctr_ent_n}, (op >= 3'd2) ? 2'b00 : 2'b11);
        chk("exec_d", ctr_d, (op == 3'd1) ? data : 8'h00);
      end else begin
        chk("done", done, 1'b1);
        chk("err", err, exp_err);
        chk("wrap", wrap, exp_wrap);
        chk("count", count, nc[7:0]);
        chk("check_ready_low", req_ready, 1'b0);
        chk_idle_pins("check");
      end
    end
    exp_count = nc;
    @(negedge clk);
    chk("ready_return", req_ready, 1'b1);
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    // Reset and INIT clear
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_s", {ctr_s1, ctr_s0}, 2'b00);
    chk("init_ready", req_ready, 1'b0);
    chk("init_count", count, 8'h00);
    chk("init_done", {done, err, wrap}, 3'b000);
    @(negedge clk);
    chk("post_init_ready", req_ready, 1'b1);
    chk("post_init_q", ctr_q, 8'h00);
    chk_idle_pins("post_init");

    // Directed cases
    run_op(3'd1, 8'h5A);
    run_op(3'd1, 8'hFD);
    run_op(3'd4, 8'h05);
    run_op(3'd1, 8'h01);
    run_op(3'd5, 8'h03);
    run_op(3'd1, 8'h10);
    run_op(3'd3, 8'h00);
    run_op(3'd7, 8'h33);
    run_op(3'd4, 8'hE0);
    run_op(3'd2, 8'h00);
    run_op(3'd0, 8'h00);

    // Readback mismatch: Q forced to 00 during INC from 0x20
    run_op(3'd1, 8'h20);
    force_en = 1'b1; force_val = 8'h00;
    run_op(3'd2, 8'h00);
    force_en = 1'b0;

    // Reset in the third step of ADD n=8
    req_valid = 1'b1; req_op = 3'd4; req_data = 8'h08;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_step3_done", done, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_init_s", {ctr_s1, ctr_s0}, 2'b00);
    chk("midrst_count", count, 8'h00);
    chk("midrst_done", done, 1'b0);
    chk("midrst_ready", req_ready, 1'b0);
    @(negedge clk);
    chk("midrst_q", ctr_q, 8'h00);
    chk("midrst_ready_back", req_ready, 1'b1);
    chk("midrst_done2", done, 1'b0);
    exp_count = 0;

    // Randomised traffic against the arithmetic reference
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/updown_counter_driver.md
Name: updown_counter_driver

Overview:
- Command-side controller for an 8-bit 74AS867-style synchronous up/down counter in the TTL-level simulation. Used as a stack pointer or loop counter.
- Takes clear/load/increment/decrement/add/subtract requests over a valid/ready handshake.
- Drives the counter's S1/S0, ENP_n, ENT_n and parallel-data pins, one counter clock per step.
- Keeps a shadow count, watches RCO_n for wrap, and reads Q back to detect pin/model mismatch.

Parameters:
- WIDTH, 8, counter and data width.
- STEP_W, 4, width of the repeat count for ADD/SUB (max 15 steps).

Ports:
- clk  input  1  system clock; counter pins change and are sampled on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_op  input  3  0 CLR, 1 LOAD, 2 INC, 3 DEC, 4 ADD, 5 SUB, 6-7 illegal.
- req_data  input  WIDTH  LOAD value; bits [STEP_W-1:0] are the step count for ADD/SUB.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: illegal op or readback mismatch.
- wrap  output  1  valid with done: at least one step wrapped (FF->00 up, 00->FF down).
- count  output  WIDTH  shadow count.
- ctr_s1, ctr_s0  output  1 each  counter mode select: 00 clear, 01 down, 10 load, 11 up.
- ctr_enp_n, ctr_ent_n  output  1 each  active-low count enables.
- ctr_d  output  WIDTH  counter parallel load data.
- ctr_rco_n  input  1  counter ripple-carry, active low.
- ctr_q  input  WIDTH  counter outputs, used for readback.

Behaviour:
- Idle pin state:
  - S1S0=11, ENP_n=ENT_n=1, ctr_d=0; the counter holds.
  - Every state except EXEC drives the idle pin state, apart from the INIT clear cycle.
- Reset:
  - count=0, done=err=wrap=0, req_ready=0, state INIT.
- INIT (1 cycle):
  - Drives S1S0=00 so the counter clears, matching shadow=0.
  - Then goes to IDLE. Reset held high re-enters INIT every cycle.
- IDLE:
  - req_ready=1. On req_valid&&req_ready, latch op, data and steps.
  - CLR, LOAD, INC, DEC: steps=1.
  - ADD, SUB: steps=req_data[STEP_W-1:0].
  - Go to EXEC, or to CHECK if the op is illegal or steps==0.
- EXEC (one cycle per step), req_ready=0:
  - CLR: S=00.
  - LOAD: S=10, ctr_d=latched data.
  - INC/ADD: S=11 with ENP_n=ENT_n=0.
  - DEC/SUB: S=01 with ENP_n=ENT_n=0.
  - Shadow update at the edge ending each step:
    - CLR: count=0.
    - LOAD: count=data.
    - Up: count+1 mod 2^WIDTH.
    - Down: count-1 mod 2^WIDTH.
  - Wrap detection: in count steps, ctr_rco_n sampled low in the same cycle sets the wrap accumulator. Up steps wrap when count==FF before the step; down steps when count==00.
  - Decrement remaining steps; at 0 go to CHECK.
- CHECK (1 cycle):
  - done=1.
  - err=1 if the op is illegal or ctr_q != count.
  - wrap=accumulator, then clear the accumulator.
  - Next state IDLE, so req_ready returns the following cycle.
- Latency:
  - Single-step op accepted at edge T: EXEC in cycle T+1, done in cycle T+2, ready again in T+3.
  - ADD/SUB of n steps: done in cycle T+1+n.
- Other rules:
  - Illegal op or n=0: no pin activity, count unchanged, done at T+1; err=1 only for illegal.
  - Requests presented while req_ready=0 are ignored (not queued); req_valid is not required to hold.
  - Reset mid-EXEC abandons the remaining steps; no done pulse; INIT clear follows.
  - A mismatch does not resync the shadow; the shadow stays authoritative.

Decomposition:
- Shared package (ttl_ctr_pkg):
  - op code constants.
  - state enum {INIT, IDLE, EXEC, CHECK}.
  - mode constants MODE_CLR=00, MODE_DOWN=01, MODE_LOAD=10, MODE_UP=11.
  - WIDTH default.
- No sub-module; one FSM plus step counter and shadow register.
- Benches pair the block with the behavioural 8-bit up/down counter model.

Test Plan:
- Reset 2 cycles -> INIT drives S=00 for 1 cycle; ctr_q=00, count=00; req_ready rises the cycle after INIT.
- LOAD 0x5A accepted at T -> cycle T+1 S=10, ctr_d=5A; done at T+2 with count=5A, err=0, wrap=0.
- LOAD 0xFD, then ADD n=5 -> 5 consecutive EXEC cycles with S=11 and enables low; count=02, wrap=1, done 6 cycles after accept.
- LOAD 0x01, then SUB n=3 -> count=FE, wrap=1; DEC from 0x10 -> count=0F, wrap=0.
- op=7 and ADD n=0 -> no pin activity, done next cycle; err=1 for op 7, err=0 for n=0; count unchanged.
- Mismatches:
  - Force ctr_q to 0x00 during INC from 0x20 -> done with err=1, count=21.
  - Assert rst in the 3rd step of ADD n=8 -> no done, INIT clear, count=00.
